// File: rtl/restador_pkg.sv
// restador_pkg
//   Shared definitions for the bit-serial subtractor slice.
//   - R4_WIDTH   : default operand width.
//   - r4_state_e : controller states (IDLE, SHIFT, DONE).
package restador_pkg;

    localparam int unsigned R4_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } r4_state_e;

endpackage

// File: rtl/restador_completo.sv
// restador_completo
//   Combinational full-subtractor cell: computes a - b - bin for one bit.
//   Ports:
//     a    in  : minuend bit
//     b    in  : subtrahend bit
//     bin  in  : borrow in
//     d    out : difference bit
//     bout out : borrow out
module restador_completo (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        // Borrow when b exceeds a, or when they are equal and a borrow arrives.
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/restador_serie_4bits.sv
// restador_serie_4bits
//   Bit-serial subtractor computing A - B - Bin, LSB first, one bit per clock
//   through a single full-subtractor cell and a registered borrow.
//   Ports:
//     clk       in  : system clock, rising edge
//     rst       in  : asynchronous active-high reset
//     r4_start  in  : request, sampled only in IDLE
//     r4_a      in  : minuend, latched on accepted start
//     r4_b      in  : subtrahend, latched on accepted start
//     r4_bin    in  : borrow in, latched on accepted start
//     r4_diff   out : difference, valid from the done cycle until next start
//     r4_bout   out : final borrow out, same validity as r4_diff
//     r4_busy   out : high in SHIFT and DONE
//     r4_done   out : one-cycle pulse when the result becomes valid
module restador_serie_4bits
    import restador_pkg::*;
#(
    parameter int unsigned N = R4_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r4_start,
    input  logic [N-1:0] r4_a,
    input  logic [N-1:0] r4_b,
    input  logic         r4_bin,
    output logic [N-1:0] r4_diff,
    output logic         r4_bout,
    output logic         r4_busy,
    output logic         r4_done
);

    localparam int unsigned CW = $clog2(N) + 1;

    r4_state_e      state_q, state_d;
    logic [N-1:0]   a_q,    a_d;
    logic [N-1:0]   b_q,    b_d;
    logic [N-1:0]   diff_q, diff_d;
    logic [CW-1:0]  cnt_q,  cnt_d;
    logic           brw_q,  brw_d;
    logic           bout_q, bout_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           fs_d;
    logic           fs_bout;

    restador_completo u_completo (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (brw_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (r4_start) begin
                    a_d     = r4_a;
                    b_d     = r4_b;
                    brw_d   = r4_bin;
                    cnt_d   = '0;
                    diff_d  = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // New bit enters at the MSB; after N shifts bit 0 sits at the LSB.
                diff_d = N'({fs_d, diff_q} >> 1);
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                brw_d  = fs_bout;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Only the MSB borrow is published; intermediate ones stay internal.
                    bout_d  = fs_bout;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign r4_diff = diff_q;
    assign r4_bout = bout_q;
    assign r4_busy = busy_q;
    assign r4_done = done_q;

endmodule
